// File: rtl/jtpang_video_pkg.sv
// rtl/jtpang_video_pkg.sv - shared pang video timing constants and helpers
package jtpang_video_pkg;

    // Default pang raster geometry
    localparam int HCNT_END = 511;
    localparam int HB_START = 459;
    localparam int HB_END   = 75;
    localparam int HS_START = 495;
    localparam int VCNT_END = 271;
    localparam int VB_START = 247;
    localparam int VB_END   = 7;
    localparam int VS_START = 263;
    localparam int HOFFSET  = 12;

    typedef logic [8:0] cnt_t;

    // Ceiling log2, never below 1 so it can size a register directly
    function automatic int clog2(input int n);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < n) begin
            p = p * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // (a + b) mod (last + 1), summed 10 bits wide so the carry is not lost
    function automatic cnt_t wrap_add(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] last);
        logic [9:0] s;
        s = a + b;
        if (s > last) begin
            s = s - (last + 10'd1);
        end
        return s[8:0];
    endfunction

endpackage

// File: rtl/jtpang_vtiming_if.sv
// rtl/jtpang_vtiming_if.sv - raster interrupt request/acknowledge bundle
interface jtpang_vtiming_if #(
    parameter int IRQ_CH = 2
);
    logic [9*IRQ_CH-1:0] irq_line;
    logic [IRQ_CH-1:0]   irq_en;
    logic [IRQ_CH-1:0]   irq_ack;
    logic [IRQ_CH-1:0]   irq_pend;
    logic                int_n;

    // CPU side programs lines and acknowledges
    modport master (
        output irq_line,
        output irq_en,
        output irq_ack,
        input  irq_pend,
        input  int_n
    );

    // Timing block raises pending flags
    modport slave (
        input  irq_line,
        input  irq_en,
        input  irq_ack,
        output irq_pend,
        output int_n
    );
endinterface

// File: rtl/jtpang_frac_cen.sv
// rtl/jtpang_frac_cen.sv - fractional pxl2_cen generator with divide-by-2 pxl_cen
module jtpang_frac_cen
    import jtpang_video_pkg::*;
#(
    parameter int CEN_N = 1,
    parameter int CEN_M = 3
) (
    input  logic clk,
    input  logic rst,
    output logic pxl2_cen,
    output logic pxl_cen
);

    // One extra bit so acc + CEN_N (always < 2*CEN_M) never overflows
    localparam int            WC   = clog2(CEN_M) + 1;
    localparam logic [WC-1:0] STEP = WC'(CEN_N);
    localparam logic [WC-1:0] MODV = WC'(CEN_M);

    logic [WC-1:0] acc_q, acc_d;
    logic [WC-1:0] sum;
    logic          pxl2_cen_q, pxl2_cen_d;
    logic          pxl_cen_q, pxl_cen_d;
    logic          tog_q, tog_d;

    // Accumulate CEN_N per clk, emit a pulse each time CEN_M is crossed;
    // every other pulse also becomes pxl_cen, starting with the second one
    always_comb begin
        sum        = acc_q + STEP;
        acc_d      = sum;
        pxl2_cen_d = 1'b0;
        pxl_cen_d  = 1'b0;
        tog_d      = tog_q;
        if (sum >= MODV) begin
            acc_d      = sum - MODV;
            pxl2_cen_d = 1'b1;
            pxl_cen_d  = tog_q;
            tog_d      = ~tog_q;
        end
    end

    // Accumulator, toggle and registered enables
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            tog_q      <= 1'b0;
            pxl2_cen_q <= 1'b0;
            pxl_cen_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            tog_q      <= tog_d;
            pxl2_cen_q <= pxl2_cen_d;
            pxl_cen_q  <= pxl_cen_d;
        end
    end

    assign pxl2_cen = pxl2_cen_q;
    assign pxl_cen  = pxl_cen_q;

endmodule

// File: rtl/jtpang_vtiming.sv
// rtl/jtpang_vtiming.sv - pang video timing: counters, blanking, sync and raster IRQs
module jtpang_vtiming
    import jtpang_video_pkg::*;
#(
    parameter int CEN_N    = 1,
    parameter int CEN_M    = 3,
    parameter int HCNT_END = jtpang_video_pkg::HCNT_END,
    parameter int HB_START = jtpang_video_pkg::HB_START,
    parameter int HB_END   = jtpang_video_pkg::HB_END,
    parameter int HS_START = jtpang_video_pkg::HS_START,
    parameter int HS_LEN   = 32,
    parameter int VCNT_END = jtpang_video_pkg::VCNT_END,
    parameter int VB_START = jtpang_video_pkg::VB_START,
    parameter int VB_END   = jtpang_video_pkg::VB_END,
    parameter int VS_START = jtpang_video_pkg::VS_START,
    parameter int VS_LEN   = 3,
    parameter int IRQ_CH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flip,
    output logic             pxl2_cen,
    output logic             pxl_cen,
    output logic [8:0]       h,
    output logic [8:0]       v,
    output logic [8:0]       hf,
    output logic [7:0]       vf,
    output logic             LHBL,
    output logic             LVBL,
    output logic             HS,
    output logic             VS,
    jtpang_vtiming_if.slave  irq
);

    localparam cnt_t H_LAST = cnt_t'(HCNT_END);
    localparam cnt_t V_LAST = cnt_t'(VCNT_END);
    localparam cnt_t HB_S   = cnt_t'(HB_START);
    localparam cnt_t HB_E   = cnt_t'(HB_END);
    localparam cnt_t VB_S   = cnt_t'(VB_START);
    localparam cnt_t VB_E   = cnt_t'(VB_END);
    localparam cnt_t HS_S   = cnt_t'(HS_START);
    localparam cnt_t VS_S   = cnt_t'(VS_START);
    // Sync ends may wrap past the last count into the next line/frame
    localparam cnt_t HS_E   = wrap_add(10'(HS_START), 10'(HS_LEN), 10'(HCNT_END));
    localparam cnt_t VS_E   = wrap_add(10'(VS_START), 10'(VS_LEN), 10'(VCNT_END));

    cnt_t              h_q, h_d;
    cnt_t              v_q, v_d;
    logic              lhbl_q, lhbl_d;
    logic              lvbl_q, lvbl_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [IRQ_CH-1:0] pend_q, pend_d;
    logic [IRQ_CH-1:0] irq_set;
    logic              int_n_q, int_n_d;
    logic              at_hb_start;

    jtpang_frac_cen #(
        .CEN_N    (CEN_N),
        .CEN_M    (CEN_M)
    ) u_cen (
        .clk      (clk),
        .rst      (rst),
        .pxl2_cen (pxl2_cen),
        .pxl_cen  (pxl_cen)
    );

    // Shared strobe: one pixel at the start of hblank, also the IRQ set point
    assign at_hb_start = pxl_cen & (h_q == HB_S);

    // Counters, blanking and sync all move only on pixel enables
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        lhbl_d = lhbl_q;
        lvbl_d = lvbl_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        if (pxl_cen) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + 9'd1;
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + 9'd1;
            end
            if (h_q == HB_S) begin
                lhbl_d = 1'b0;
                if (v_q == VB_S) lvbl_d = 1'b0;
                if (v_q == VB_E) lvbl_d = 1'b1;
            end
            if (h_q == HB_E) begin
                lhbl_d = 1'b1;
            end
            if (h_q == HS_S) begin
                hs_d = 1'b1;
                if (v_q == VS_S) vs_d = 1'b1;
                if (v_q == VS_E) vs_d = 1'b0;
            end
            if (h_q == HS_E) begin
                hs_d = 1'b0;
            end
        end
    end

    // Raster IRQ channels: a set in the same clk as an ack takes priority.
    // Lines beyond the last V count simply never match.
    for (genvar k = 0; k < IRQ_CH; k++) begin : g_irq
        assign irq_set[k] = at_hb_start & irq.irq_en[k]
                          & (v_q == irq.irq_line[9*k +: 9]);
        assign pend_d[k]  = irq_set[k] | (pend_q[k] & ~irq.irq_ack[k]);
    end

    // int_n follows the next-state flags so it moves with irq_pend
    always_comb begin
        int_n_d = ~|pend_d;
    end

    // Timing and IRQ state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            lhbl_q  <= 1'b0;
            lvbl_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            pend_q  <= '0;
            int_n_q <= 1'b1;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            lhbl_q  <= lhbl_d;
            lvbl_q  <= lvbl_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            pend_q  <= pend_d;
            int_n_q <= int_n_d;
        end
    end

    assign h            = h_q;
    assign v            = v_q;
    assign hf           = h_q ^ {9{flip}};
    assign vf           = v_q[7:0] ^ {8{flip}};
    assign LHBL         = lhbl_q;
    assign LVBL         = lvbl_q;
    assign HS           = hs_q;
    assign VS           = vs_q;
    assign irq.irq_pend = pend_q;
    assign irq.int_n    = int_n_q;

endmodule

// File: tb/tb_jtpang_vtiming.sv
// tb/tb_jtpang_vtiming.sv - scoreboard bench for jtpang_vtiming
module tb_jtpang_vtiming;

    // Shrunken raster so whole frames fit in a short run
    localparam int HE = 31, HBS = 23, HBE = 4, HSS = 27, HSL = 6;
    localparam int VE = 19, VBS = 15, VBE = 2, VSS = 17, VSL = 4;
    localparam int WAIT_MAX = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flip = 1'b0;
    logic       pxl2_cen, pxl_cen, LHBL, LVBL, HS, VS;
    logic [8:0] h, v, hf;
    logic [7:0] vf;
    logic       b_pxl2_cen, b_pxl_cen, b_LHBL, b_LVBL, b_HS, b_VS;
    logic [8:0] b_h, b_v, b_hf;
    logic [7:0] b_vf;

    jtpang_vtiming_if #(.IRQ_CH(2)) irq_if ();
    jtpang_vtiming_if #(.IRQ_CH(2)) irq_if2 ();

    jtpang_vtiming #(
        .CEN_N(1), .CEN_M(3),
        .HCNT_END(HE), .HB_START(HBS), .HB_END(HBE), .HS_START(HSS), .HS_LEN(HSL),
        .VCNT_END(VE), .VB_START(VBS), .VB_END(VBE), .VS_START(VSS), .VS_LEN(VSL),
        .IRQ_CH(2)
    ) dut (
        .clk(clk), .rst(rst), .flip(flip), .pxl2_cen(pxl2_cen), .pxl_cen(pxl_cen),
        .h(h), .v(v), .hf(hf), .vf(vf), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .irq(irq_if)
    );

    jtpang_vtiming #(.CEN_N(2), .CEN_M(5), .IRQ_CH(2)) dut2 (
        .clk(clk), .rst(rst), .flip(1'b0), .pxl2_cen(b_pxl2_cen), .pxl_cen(b_pxl_cen),
        .h(b_h), .v(b_v), .hf(b_hf), .vf(b_vf), .LHBL(b_LHBL), .LVBL(b_LVBL),
        .HS(b_HS), .VS(b_VS), .irq(irq_if2)
    );

    always #5 clk = ~clk;

    typedef enum int {S_H, S_V, S_HF, S_VF, S_LHBL, S_LVBL, S_HS, S_VS, S_P2, S_P1,
                      S_PEND, S_INTN, S_B2, S_B1, S_MEAS} sel_e;
    typedef struct {string name; sel_e sel; int exp; int act;} chk_t;
    typedef struct {logic [1:0] pend; bit chk_hv; int eh; int ev;} irq_t;

    chk_t chk_q[$];
    irq_t irq_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic [1:0] pend_prev = 2'b00;

    task automatic expect_sig(input string name, input sel_e sel, input int exp);
        chk_t c;
        c.name = name; c.sel = sel; c.exp = exp; c.act = 0;
        chk_q.push_back(c);
    endtask

    task automatic expect_meas(input string name, input int act, input int exp);
        chk_t c;
        c.name = name; c.sel = S_MEAS; c.exp = exp; c.act = act;
        chk_q.push_back(c);
    endtask

    task automatic expect_irq(input logic [1:0] pend, input bit chk_hv, input int eh, input int ev);
        irq_t e;
        e.pend = pend; e.chk_hv = chk_hv; e.eh = eh; e.ev = ev;
        irq_q.push_back(e);
    endtask

    function automatic int sample(input sel_e s);
        case (s)
            S_H:     return int'(h);
            S_V:     return int'(v);
            S_HF:    return int'(hf);
            S_VF:    return int'(vf);
            S_LHBL:  return int'(LHBL);
            S_LVBL:  return int'(LVBL);
            S_HS:    return int'(HS);
            S_VS:    return int'(VS);
            S_P2:    return int'(pxl2_cen);
            S_P1:    return int'(pxl_cen);
            S_PEND:  return int'(irq_if.irq_pend);
            S_INTN:  return int'(irq_if.int_n);
            S_B2:    return int'(b_pxl2_cen);
            S_B1:    return int'(b_pxl_cen);
            default: return -1;
        endcase
    endfunction

    // Scoreboard: drain queued expectations against the outputs
    always @(negedge clk) begin : sb_mon
        chk_t c;
        int   a;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            a = (c.sel == S_MEAS) ? c.act : sample(c.sel);
            n_chk++;
            if (a != c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", c.name, a, c.exp);
            end
        end
    end

    // IRQ monitor: every change of irq_pend must match the next queued event
    always @(negedge clk) begin : irq_mon
        irq_t e;
        if (irq_if.irq_pend !== pend_prev) begin
            n_chk++;
            if (irq_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_unexpected: irq_pend=%b (was %b) at h=%0d v=%0d, no change expected",
                         irq_if.irq_pend, pend_prev, h, v);
            end else begin
                e = irq_q.pop_front();
                if (irq_if.irq_pend !== e.pend || irq_if.int_n !== ~|e.pend ||
                    (e.chk_hv && (h !== e.eh[8:0] || v !== e.ev[8:0]))) begin
                    n_fail++;
                    $display("FAIL irq_event: got pend=%b int_n=%b h=%0d v=%0d, expected pend=%b int_n=%b h=%0d v=%0d",
                             irq_if.irq_pend, irq_if.int_n, h, v, e.pend, ~|e.pend, e.eh, e.ev);
                end
            end
            pend_prev = irq_if.irq_pend;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out, expected event never seen", what);
    endtask

    // Advance until the counters newly reach (wh, wv)
    task automatic wait_hv(input int wh, input int wv);
        int  ph, pv;
        bit  hit;
        ph = int'(h); pv = int'(v); hit = 0;
        for (int n = 0; n < WAIT_MAX && !hit; n++) begin
            tick();
            if (int'(h) == wh && int'(v) == wv && !(ph == wh && pv == wv)) hit = 1;
            ph = int'(h); pv = int'(v);
        end
        if (!hit) timeout($sformatf("wait_hv_%0d_%0d", wh, wv));
    endtask

    task automatic step_px();
        int ph;
        bit hit;
        ph = int'(h); hit = 0;
        for (int n = 0; n < 20 && !hit; n++) begin
            tick();
            if (int'(h) != ph) hit = 1;
        end
        if (!hit) timeout("step_px");
    endtask

    task automatic wait_pend(input logic [1:0] want);
        bit hit;
        hit = 0;
        for (int n = 0; n < WAIT_MAX && !hit; n++) begin
            tick();
            if (irq_if.irq_pend === want) hit = 1;
        end
        if (!hit) timeout($sformatf("wait_pend_%b", want));
    endtask

    task automatic pulse_ack(input logic [1:0] m);
        irq_if.irq_ack = m;
        tick();
        irq_if.irq_ack = 2'b00;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_sig({tag, "_h"}, S_H, 0);
        expect_sig({tag, "_v"}, S_V, 0);
        expect_sig({tag, "_lhbl"}, S_LHBL, 0);
        expect_sig({tag, "_lvbl"}, S_LVBL, 0);
        expect_sig({tag, "_hs"}, S_HS, 0);
        expect_sig({tag, "_vs"}, S_VS, 0);
        expect_sig({tag, "_pxl2"}, S_P2, 0);
        expect_sig({tag, "_pxl"}, S_P1, 0);
        expect_sig({tag, "_pend"}, S_PEND, 0);
        expect_sig({tag, "_int_n"}, S_INTN, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   n2, n1, f2, f1, l2, l1, bad2, bad1, m2, m1, bad5, c0, c1;
        irq_t e;
        irq_if.irq_line = '0;  irq_if.irq_en = '0;  irq_if.irq_ack = '0;
        irq_if2.irq_line = '0; irq_if2.irq_en = '0; irq_if2.irq_ack = '0;

        // Reset state
        repeat (3) tick();
        expect_reset_state("rst");
        expect_sig("rst_b_pxl2", S_B2, 0);
        expect_sig("rst_b_pxl", S_B1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Enable cadence on both instances over 1000 clk
        n2 = 0; n1 = 0; f2 = 0; f1 = 0; l2 = 0; l1 = 0; bad2 = 0; bad1 = 0;
        m2 = 0; m1 = 0; bad5 = 0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (pxl2_cen) begin
                if (l2 != 0 && i - l2 != 3) bad2++;
                if (l2 == 0) f2 = i;
                l2 = i; n2++;
            end
            if (pxl_cen) begin
                if ((l1 != 0 && i - l1 != 6) || !pxl2_cen) bad1++;
                if (l1 == 0) f1 = i;
                l1 = i; n1++;
            end
            if (b_pxl2_cen) m2++;
            if (b_pxl_cen) m1++;
            if (i % 10 == 0 && (m2 != i * 2 / 5 || m1 != i / 5)) bad5++;
        end
        expect_meas("first_pxl2_clk", f2, 3);
        expect_meas("first_pxl_clk", f1, 6);
        expect_meas("pxl2_gap_errs", bad2, 0);
        expect_meas("pxl_gap_errs", bad1, 0);
        expect_meas("pxl2_count", n2, 333);
        expect_meas("pxl_count", n1, 166);
        expect_meas("b_pxl2_count", m2, 400);
        expect_meas("b_pxl_count", m1, 200);
        expect_meas("b_window_errs", bad5, 0);
        expect_sig("h_after_1000", S_H, 6);
        expect_sig("v_after_1000", S_V, 5);
        expect_meas("b_h_after_1000", int'(b_h), 199);

        // Horizontal blank and sync widths over one line
        wait_hv(0, 6);
        c0 = 0; c1 = 0;
        for (int p = 0; p < HE + 1; p++) begin
            if (p > 0) step_px();
            if (!LHBL) c0++;
            if (HS) c1++;
        end
        expect_meas("lhbl_low_pixels", c0, 13);
        expect_meas("hs_high_pixels", c1, HSL);

        // Vertical blank and sync widths over one frame, sampled at h=0
        c0 = 0; c1 = 0;
        for (int l = 0; l < VE + 1; l++) begin
            wait_hv(0, (7 + l) % (VE + 1));
            if (!LVBL) c0++;
            if (VS) c1++;
        end
        expect_meas("lvbl_low_lines", c0, 7);
        expect_meas("vs_high_lines", c1, VSL);
        expect_sig("frame_wrap_h", S_H, 0);

        // Flip outputs and blank edges
        flip = 1'b1;
        wait_hv(4, 10);
        expect_sig("lhbl_at_hb_end", S_LHBL, 0);
        wait_hv(5, 10);
        expect_sig("hf_flip", S_HF, 9'h1FA);
        expect_sig("vf_flip", S_VF, 8'hF5);
        expect_sig("lhbl_after_hb_end", S_LHBL, 1);
        tick();
        flip = 1'b0;
        expect_sig("hf_noflip", S_HF, 5);
        expect_sig("vf_noflip", S_VF, 10);
        wait_hv(24, 16);
        expect_sig("lhbl_in_blank", S_LHBL, 0);
        expect_sig("lvbl_in_blank", S_LVBL, 0);
        expect_sig("hs_before_start", S_HS, 0);
        wait_hv(27, 17);
        expect_sig("hs_at_start", S_HS, 0);
        expect_sig("vs_at_start", S_VS, 0);
        wait_hv(28, 17);
        expect_sig("hs_after_start", S_HS, 1);
        expect_sig("vs_after_start", S_VS, 1);
        wait_hv(2, 0);
        expect_sig("hs_after_wrap_end", S_HS, 0);
        expect_sig("vs_wrapped", S_VS, 1);
        expect_sig("lvbl_line0", S_LVBL, 0);

        // Channel 0 raster IRQ, ack, idle ack
        irq_if.irq_line[8:0] = 9'd16;
        irq_if.irq_en = 2'b01;
        expect_irq(2'b01, 1, HBS + 1, 16);
        wait_pend(2'b01);
        irq_if.irq_en = 2'b00;
        repeat (20) tick();
        expect_sig("pend_kept_en_off", S_PEND, 1);
        expect_sig("int_n_low", S_INTN, 0);
        expect_irq(2'b00, 0, 0, 0);
        pulse_ack(2'b01);
        expect_sig("pend_acked", S_PEND, 0);
        repeat (3) tick();
        pulse_ack(2'b01);
        repeat (3) tick();

        // Ack held across the set event: set wins
        wait_hv(0, 16);
        irq_if.irq_ack = 2'b01;
        irq_if.irq_en = 2'b01;
        expect_irq(2'b01, 1, HBS + 1, 16);
        wait_pend(2'b01);
        irq_if.irq_ack = 2'b00;
        irq_if.irq_en = 2'b00;
        repeat (3) tick();
        expect_sig("pend_set_wins", S_PEND, 1);
        expect_irq(2'b00, 0, 0, 0);
        pulse_ack(2'b01);

        // Two independent channels
        irq_if.irq_line = {9'd12, 9'd5};
        irq_if.irq_en = 2'b11;
        expect_irq(2'b01, 1, HBS + 1, 5);
        expect_irq(2'b11, 1, HBS + 1, 12);
        wait_pend(2'b11);
        irq_if.irq_en = 2'b00;
        expect_irq(2'b10, 0, 0, 0);
        pulse_ack(2'b01);
        expect_sig("int_n_ch1_still", S_INTN, 0);
        expect_sig("pend_ch1_only", S_PEND, 2);
        expect_irq(2'b00, 0, 0, 0);
        pulse_ack(2'b10);

        // Lines past the last V count never fire (low bits alias valid lines)
        irq_if.irq_line = {9'd268, 9'd260};
        irq_if.irq_en = 2'b11;
        wait_hv(0, 0);
        wait_hv(0, 0);
        expect_sig("pend_out_of_range", S_PEND, 0);
        irq_if.irq_en = 2'b00;

        // Reset mid-frame with a pending flag
        irq_if.irq_line = {9'd0, 9'd8};
        irq_if.irq_en = 2'b01;
        expect_irq(2'b01, 1, HBS + 1, 8);
        wait_pend(2'b01);
        irq_if.irq_en = 2'b00;
        wait_hv(3, 10);
        rst = 1'b1;
        expect_irq(2'b00, 0, 0, 0);
        tick();
        expect_reset_state("midrst");
        rst = 1'b0;
        c0 = 0;
        for (int i = 1; i <= 10 && c0 == 0; i++) begin
            tick();
            if (pxl2_cen) c0 = i;
        end
        expect_meas("midrst_first_pxl2", c0, 3);

        repeat (5) tick();
        while (irq_q.size() > 0) begin
            e = irq_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL irq_missing: got no change, expected irq_pend=%b", e.pend);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
